// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the RAM controller's single cache-side port between
// two requesters; a watchdog completes a transaction whose controller ack never arrives.
module ram_port_arbiter #(
  parameter int ADDR_SIZE      = 13,
  parameter int CASH_STR_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      not_reset,
  input  logic                      req0_avalid,
  input  logic [ADDR_SIZE-1:0]      req0_addr,
  input  logic                      req0_rnw,
  input  logic [CASH_STR_WIDTH-1:0] req0_wdata,
  output logic                      req0_ack,
  output logic [CASH_STR_WIDTH-1:0] req0_rdata,
  input  logic                      req1_avalid,
  input  logic [ADDR_SIZE-1:0]      req1_addr,
  input  logic                      req1_rnw,
  input  logic [CASH_STR_WIDTH-1:0] req1_wdata,
  output logic                      req1_ack,
  output logic [CASH_STR_WIDTH-1:0] req1_rdata,
  output logic                      ctrl_avalid,
  output logic [ADDR_SIZE-1:0]      ctrl_addr,
  output logic                      ctrl_rnw,
  output logic [CASH_STR_WIDTH-1:0] ctrl_wdata,
  input  logic                      ctrl_ack,
  input  logic [CASH_STR_WIDTH-1:0] ctrl_rdata,
  output logic                      busy,
  output logic                      err_timeout,
  output logic [1:0]                dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_gnt_id;
  logic                      r_last_grant;
  logic [TW-1:0]             r_timer;
  logic [TW-1:0]             w_timer_inc;
  logic                      w_grant;
  logic                      w_pick;
  logic                      w_done;
  logic                      w_expire;
  logic                      r_ack0;
  logic                      r_ack1;
  logic [CASH_STR_WIDTH-1:0] r_rdata0;
  logic [CASH_STR_WIDTH-1:0] r_rdata1;
  logic                      r_ctrl_avalid;
  logic [ADDR_SIZE-1:0]      r_ctrl_addr;
  logic                      r_ctrl_rnw;
  logic [CASH_STR_WIDTH-1:0] r_ctrl_wdata;
  logic                      r_busy;
  logic                      r_err;

  // Handshake: a requester holds avalid (and its fields) until it samples its
  // one-cycle ack, then drops avalid on that same edge; ctrl_avalid is a
  // one-cycle pulse and ctrl_ack is a one-cycle completion pulse.
  assign w_pick      = (req0_avalid && req1_avalid) ? ~r_last_grant : req1_avalid;
  assign w_timer_inc = r_timer + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_avalid || req1_avalid) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ctrl_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A controller ack landing on the expiry cycle still counts as success.
        if (ctrl_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_timer_inc == TMO) begin
          w_expire    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_state       <= S_IDLE;
      r_gnt_id      <= 1'b0;
      r_last_grant  <= 1'b1;
      r_timer       <= '0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
      r_ctrl_avalid <= 1'b0;
      r_ctrl_addr   <= '0;
      r_ctrl_rnw    <= 1'b0;
      r_ctrl_wdata  <= '0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_ctrl_avalid <= w_grant;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      if (w_grant) begin
        r_gnt_id     <= w_pick;
        r_last_grant <= w_pick;
        r_ctrl_addr  <= w_pick ? req1_addr  : req0_addr;
        r_ctrl_rnw   <= w_pick ? req1_rnw   : req0_rnw;
        r_ctrl_wdata <= w_pick ? req1_wdata : req0_wdata;
      end
      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT) begin
        r_timer <= w_timer_inc;
      end
      if (w_done || w_expire) begin
        if (r_gnt_id) begin
          r_ack1   <= 1'b1;
          r_rdata1 <= w_done ? ctrl_rdata : '0;
        end else begin
          r_ack0   <= 1'b1;
          r_rdata0 <= w_done ? ctrl_rdata : '0;
        end
      end
      if (w_expire) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req0_ack    = r_ack0;
  assign req0_rdata  = r_rdata0;
  assign req1_ack    = r_ack1;
  assign req1_rdata  = r_rdata1;
  assign ctrl_avalid = r_ctrl_avalid;
  assign ctrl_addr   = r_ctrl_addr;
  assign ctrl_rnw    = r_ctrl_rnw;
  assign ctrl_wdata  = r_ctrl_wdata;
  assign busy        = r_busy;
  assign err_timeout = r_err;
  assign dbg_state   = r_state;

endmodule
